// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the text-mode pixel generator.
// The timing generator drives through 'master'; the pixel generator listens through 'slave'.
interface vga_timing_if #(
    parameter int CNT_W = 10
);
    logic [CNT_W-1:0] horicount;
    logic [CNT_W-1:0] vertcount;
    logic [CNT_W-1:0] nextline;
    logic             prepline;
    logic             hsync;
    logic             vsync;
    logic             disp_en;
    logic             frame_start;

    modport master (
        output horicount, vertcount, nextline, prepline,
        output hsync, vsync, disp_en, frame_start
    );

    modport slave (
        input horicount, vertcount, nextline, prepline,
        input hsync, vsync, disp_en, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster counter with line-prepare outputs and sync/blank signals delayed
// to line up with the pixel generator's serial output at the connector.
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int PIX_LAT   = 9,
    parameter int CNT_W     = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_timing_if.master    vif
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic POL    = (SYNC_POL != 0);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t IDLE = '{hs: !POL, vs: !POL, de: 1'b0};

    if ((H_TOTAL % 8) != 0 || (H_VISIBLE % 8) != 0) begin : g_bad_char_phase
        $error("vga_timing: H_TOTAL and H_VISIBLE must be multiples of 8");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIX_LAT < 0 || PIX_LAT > 15) begin : g_bad_lat
        $error("vga_timing: PIX_LAT must be in 0..15");
    end

    function automatic sync_t decode(cnt_t h, cnt_t v);
        sync_t s;
        s.hs = ((int'(h) >= HS_START) && (int'(h) < HS_END)) ~^ POL;
        s.vs = ((int'(v) >= VS_START) && (int'(v) < VS_END)) ~^ POL;
        s.de = (int'(h) < H_VISIBLE) && (int'(v) < V_VISIBLE);
        return s;
    endfunction

    cnt_t  h_q, h_d;
    cnt_t  v_q, v_d;
    cnt_t  nl_q, nl_d;
    sync_t raw_d;

    // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == cnt_t'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == cnt_t'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end
        nl_d  = (v_d == cnt_t'(V_TOTAL - 1)) ? '0 : v_d + 1'b1;
        // Decoded from the next counter state so the registered copy lines up with h_q/v_q.
        raw_d = decode(h_d, v_d);
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            nl_q <= cnt_t'(1);
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            nl_q <= nl_d;
        end
    end

    if (PIX_LAT == 0) begin : g_no_delay
        sync_t out_q;

        always_ff @(posedge clk) begin
            if (!rst_n) out_q <= IDLE;
            else        out_q <= raw_d;
        end

        assign vif.hsync   = out_q.hs;
        assign vif.vsync   = out_q.vs;
        assign vif.disp_en = out_q.de;
    end else begin : g_delay
        sync_t raw_q;
        sync_t dly_q [PIX_LAT];
        sync_t dly_d [PIX_LAT];

        always_comb begin
            dly_d[0] = raw_q;
            for (int i = 1; i < PIX_LAT; i++) dly_d[i] = dly_q[i-1];
        end

        // NOTE: raw_q tracks the counters, so in reset it takes the origin decode; only the
        // shift stages behind it are cleared, which keeps output latency exactly PIX_LAT.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                raw_q <= decode('0, '0);
                for (int i = 0; i < PIX_LAT; i++) dly_q[i] <= IDLE;
            end else begin
                raw_q <= raw_d;
                dly_q <= dly_d;
            end
        end

        assign vif.hsync   = dly_q[PIX_LAT-1].hs;
        assign vif.vsync   = dly_q[PIX_LAT-1].vs;
        assign vif.disp_en = dly_q[PIX_LAT-1].de;
    end

    assign vif.horicount   = h_q;
    assign vif.vertcount   = v_q;
    assign vif.nextline    = nl_q;
    // The last blank line also prepares, so line 0 is ready before display starts.
    assign vif.prepline    = (int'(h_q) < H_VISIBLE) &&
                             ((int'(v_q) < V_VISIBLE) || (v_q == cnt_t'(V_TOTAL - 1)));
    assign vif.frame_start = rst_n && (h_q == '0) && (v_q == '0);
endmodule
